// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop adds two
// WIDTH-bit operands LSB-first, one bit per clock, with start/busy/done control.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             sum_bit,
    output logic             bit_valid
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             sum_bit_q, sum_bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             fa_s, fa_c;

    // The full-adder cell that every RUN cycle reuses.
    always_comb begin
        fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    // Handshake: start is taken only in IDLE; busy marks RUN, done pulses for
    // one cycle when sum/cout update. start seen in RUN or DONE is dropped.
    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        sum_bit_d   = sum_bit_q;
        bit_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sr_d      = a_sr_q >> 1;
                b_sr_d      = b_sr_q >> 1;
                res_d       = {fa_s, res_q[WIDTH-1:1]};
                carry_d     = fa_c;
                sum_bit_d   = fa_s;
                bit_valid_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            sum_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            sum_bit_q   <= sum_bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign sum_bit   = sum_bit_q;
    assign bit_valid = bit_valid_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/handshake cases
// and a 3-bit instance swept over every operand combination.
module tb_serial_adder;
    logic clk;
    logic rst;

    logic       start8, cin8, busy8, done8, cout8, sum_bit8, bit_valid8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3, sum_bit3, bit_valid3;
    logic [2:0] a3, b3, sum3;

    int n_cmp;
    int n_fail;
    logic [0:0] exp_q[$];
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .sum_bit(sum_bit8), .bit_valid(bit_valid8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3),
        .sum_bit(sum_bit3), .bit_valid(bit_valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation from IDLE; poke > 0 drives a stray start with new
    // operands after that RUN edge, which must be ignored.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] esum, input logic ecout, input int poke,
                          input string tag);
        @(posedge clk); #1;
        a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check({tag, "_busy_start"}, 32'(busy8), 32'd1);
        check({tag, "_done_start"}, 32'(done8), 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(esum[i]);
        for (int k = 1; k <= 8; k++) begin
            start8 = (k == poke);
            if (k == poke) begin
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            end
            @(posedge clk); #1;
            check({tag, "_bit_valid"}, 32'(bit_valid8), 32'd1);
            check({tag, "_sum_bit"}, 32'(sum_bit8), 32'(exp_q.pop_front()));
            if (k < 8) begin
                check({tag, "_busy_run"}, 32'(busy8), 32'd1);
                check({tag, "_done_run"}, 32'(done8), 32'd0);
                check({tag, "_sum_hold"}, 32'(sum8), 32'(last_sum));
                check({tag, "_cout_hold"}, 32'(cout8), 32'(last_cout));
            end else begin
                check({tag, "_done"}, 32'(done8), 32'd1);
                check({tag, "_busy_done"}, 32'(busy8), 32'd0);
                check({tag, "_sum"}, 32'(sum8), 32'(esum));
                check({tag, "_cout"}, 32'(cout8), 32'(ecout));
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_end"}, 32'(done8), 32'd0);
        check({tag, "_busy_end"}, 32'(busy8), 32'd0);
        check({tag, "_bit_valid_end"}, 32'(bit_valid8), 32'd0);
        last_sum = esum;
        last_cout = ecout;
    endtask

    initial begin
        int pulses;
        int last_pulse;
        bit seen;
        logic [3:0] exp3;
        n_cmp = 0; n_fail = 0;
        last_sum = 8'h00; last_cout = 1'b0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_sum_bit", 32'(sum_bit8), 32'd0);
        check("rst_bit_valid", 32'(bit_valid8), 32'd0);
        check("rst_sum3", 32'({cout3, sum3}), 32'd0);

        run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 0, "v3c5a");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "vff01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "vffff");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, "v0000c");
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "ignore");

        // Continuous start: completions every WIDTH+2 cycles.
        @(posedge clk); #1;
        a8 = 8'h81; b8 = 8'h81; cin8 = 1'b0; start8 = 1'b1;
        pulses = 0; last_pulse = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                pulses++;
                check("hold_sum", 32'(sum8), 32'h02);
                check("hold_cout", 32'(cout8), 32'd1);
                if (last_pulse > 0) check("hold_period", 32'(i - last_pulse), 32'd10);
                last_pulse = i;
            end
        end
        start8 = 1'b0;
        check("hold_pulses", 32'(pulses), 32'd3);
        @(posedge clk); #1;
        check("hold_idle", 32'(busy8), 32'd0);

        // Asynchronous abort in the middle of a run.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #5 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_bit_valid", 32'(bit_valid8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        last_sum = 8'h00; last_cout = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, "after_rst");

        // Exhaustive 3-bit sweep.
        for (int ta = 0; ta < 8; ta++) begin
            for (int tbv = 0; tbv < 8; tbv++) begin
                for (int tc = 0; tc < 2; tc++) begin
                    @(posedge clk); #1;
                    a3 = 3'(ta); b3 = 3'(tbv); cin3 = 1'(tc); start3 = 1'b1;
                    @(posedge clk); #1;
                    start3 = 1'b0;
                    seen = 1'b0;
                    for (int k = 0; k < 10 && !seen; k++) begin
                        if (done3) seen = 1'b1;
                        else begin
                            @(posedge clk); #1;
                        end
                    end
                    check("sweep3_done", 32'(seen), 32'd1);
                    exp3 = 4'(ta + tbv + tc);
                    check("sweep3_sum", 32'({cout3, sum3}), 32'(exp3));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
